mem_access_sequencer: RTL and testbench

//  Sequences RISC-V loads/stores onto a single-port synchronous data SRAM (1-cycle read latency).

---
 rtl/mem_access_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Sequences RISC-V loads/stores onto a single-port 1-cycle-latency SRAM; sub-word stores use read-modify-write.
// Latency accept->rsp: load/sb/sh 2 cycles, sw 1, error 1. Backpressure: req_ready_o only in IDLE, responses never stall.
module mem_access_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RESP  = 3'd2,
        S_MERGE = 3'd3,
        S_WRITE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic                    r_rsp_valid;
    logic                    r_rsp_error;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_write;
    logic [2:0]              r_funct3;
    logic [1:0]              r_off;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_req_err;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic [7:0]              w_rd_byte;
    logic [15:0]             w_rd_half;
    logic [DATA_WIDTH-1:0]   w_load_dat;
    logic [DATA_WIDTH-1:0]   w_merge_dat;

    // Upper address bits wrap modulo SRAM depth and are intentionally dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

    assign w_accept    = req_valid_i && r_ready;
    assign w_word_addr = req_addr_i[ADDR_WIDTH+1:2];

    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3_i)
            3'b000:  w_req_err = 1'b0;
            3'b001:  w_req_err = req_addr_i[0];
            3'b010:  w_req_err = |req_addr_i[1:0];
            3'b100:  w_req_err = req_write_i;
            3'b101:  w_req_err = req_write_i | req_addr_i[0];
            default: w_req_err = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_off)
            2'd0: w_rd_byte = mem_rdata_i[7:0];
            2'd1: w_rd_byte = mem_rdata_i[15:8];
            2'd2: w_rd_byte = mem_rdata_i[23:16];
            2'd3: w_rd_byte = mem_rdata_i[31:24];
            default: w_rd_byte = 8'h00;
        endcase
    end

    assign w_rd_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        w_load_dat = mem_rdata_i;
        case (r_funct3)
            3'b000:  w_load_dat = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b100:  w_load_dat = {24'h000000, w_rd_byte};
            3'b001:  w_load_dat = {{16{w_rd_half[15]}}, w_rd_half};
            3'b101:  w_load_dat = {16'h0000, w_rd_half};
            default: w_load_dat = mem_rdata_i;
        endcase
    end

    // Read-modify-write: only the addressed lane(s) take store data, the rest keep SRAM contents.
    always_comb begin
        w_merge_dat = mem_rdata_i;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_off)
                2'd0: w_merge_dat[7:0]   = r_wdata[7:0];
                2'd1: w_merge_dat[15:8]  = r_wdata[7:0];
                2'd2: w_merge_dat[23:16] = r_wdata[7:0];
                2'd3: w_merge_dat[31:24] = r_wdata[7:0];
                default: w_merge_dat = mem_rdata_i;
            endcase
        end else if (r_off[1]) begin
            w_merge_dat[31:16] = r_wdata[15:0];
        end else begin
            w_merge_dat[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write_i;
                        r_funct3 <= req_funct3_i;
                        r_off    <= req_addr_i[1:0];
                        r_wdata  <= req_wdata_i;
                        r_ready  <= 1'b0;
                        if (w_req_err) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                        end else if (req_write_i && req_funct3_i == 3'b010) begin
                            r_state     <= S_WRITE;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state    <= S_READ;
                            r_mem_en   <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_word_addr;
                        end
                    end
                end
                S_READ: begin
                    r_rsp_valid <= 1'b1;
                    if (r_write) begin
                        r_state  <= S_MERGE;
                        r_mem_we <= 1'b1;
                    end else begin
                        r_state    <= S_RESP;
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_error_o = r_rsp_error;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign rsp_rdata_o = (r_state == S_RESP) ? w_load_dat : '0;
    assign mem_wdata_o = (r_state == S_MERGE) ? w_merge_dat :
                         (r_state == S_WRITE) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural SRAM and an in-order response scoreboard.
module tb_mem_access_sequencer;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_dat;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;

    mem_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_error_o  (rsp_error),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en === 1'b1) en_cnt <= en_cnt + 1;
        if (bd_we) mem[bd_addr] <= bd_dat;
        else if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_pending", sb.size(), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
        if (mem_we === 1'b1) chk("we_needs_en", {31'b0, mem_en}, 32'd1);
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_dat  = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input bit hold, input bit push);
        int n;
        exp_t e;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", n, 32'd0);
        end else if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int en_before;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        preload(10'd4, 32'hDEADBEEF);
        send(1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1);
        chk("lw_read_en", {31'b0, mem_en}, 32'd1);
        chk("lw_read_we", {31'b0, mem_we}, 32'd0);
        chk("lw_read_addr", {22'b0, mem_addr}, 32'd4);
        chk("lw_busy_ready", {31'b0, req_ready}, 32'd0);
        drain();

        preload(10'd4, 32'h80FF1234);
        send(1'b0, F_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_HU, 32'h12, 32'h0, 32'h000080FF, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_H,  32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_B,  32'h10, 32'h0, 32'h00000034, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_H,  32'h10, 32'h0, 32'h00001234, 1'b0, 2, 1'b0, 1'b1);
        send(1'b0, F_W,  32'hFFFF_1010, 32'h0, 32'h80FF1234, 1'b0, 2, 1'b0, 1'b1);
        drain();

        preload(10'd4, 32'h11223344);
        send(1'b1, F_B, 32'h11, 32'hFFFFFFAB, 32'h0, 1'b0, 2, 1'b0, 1'b1);
        @(negedge clk);
        chk("sb_merge_we", {31'b0, mem_we}, 32'd1);
        chk("sb_merge_wdata", mem_wdata, 32'h1122AB44);
        chk("sb_merge_addr", {22'b0, mem_addr}, 32'd4);
        drain();
        chk("sb_mem", mem[4], 32'h1122AB44);

        preload(10'd5, 32'h00000000);
        send(1'b1, F_H, 32'h16, 32'h1234CAFE, 32'h0, 1'b0, 2, 1'b0, 1'b1);
        drain();
        chk("sh_mem", mem[5], 32'hCAFE0000);

        en_before = en_cnt;
        send(1'b1, F_W, 32'h18, 32'h12345678, 32'h0, 1'b0, 1, 1'b0, 1'b1);
        chk("sw_we", {31'b0, mem_we}, 32'd1);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        chk("sw_addr", {22'b0, mem_addr}, 32'd6);
        drain();
        chk("sw_mem", mem[6], 32'h12345678);
        chk("sw_single_access", en_cnt - en_before, 32'd1);

        en_before = en_cnt;
        send(1'b0, F_H,    32'h03, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        send(1'b1, F_W,    32'h02, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        send(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        send(1'b1, F_BU,   32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        send(1'b0, F_HU,   32'h11, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        chk("err_no_mem_en", en_cnt - en_before, 32'd0);

        preload(10'd4, 32'h11223344);
        send(1'b1, F_B, 32'h11, 32'h000000AB, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_mid_mem", mem[4], 32'h11223344);

        preload(10'd8, 32'hA5A5A5A5);
        preload(10'd9, 32'h00000000);
        send(1'b0, F_W,    32'h20, 32'h0,        32'hA5A5A5A5, 1'b0, 2, 1'b1, 1'b1);
        send(1'b1, F_B,    32'h21, 32'hFFFFFF5A, 32'h0,        1'b0, 2, 1'b1, 1'b1);
        send(1'b0, F_BU,   32'h21, 32'h0,        32'h0000005A, 1'b0, 2, 1'b1, 1'b1);
        send(1'b1, F_W,    32'h24, 32'h0BADF00D, 32'h0,        1'b0, 1, 1'b1, 1'b1);
        send(1'b0, F_W,    32'h24, 32'h0,        32'h0BADF00D, 1'b0, 2, 1'b1, 1'b1);
        send(1'b0, 3'b111, 32'h24, 32'h0,        32'h0,        1'b1, 1, 1'b0, 1'b1);
        drain();
        chk("b2b_mem8", mem[8], 32'hA5A55AA5);
        chk("b2b_mem9", mem[9], 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
